pipe_stage_buf: RTL and testbench

//  Generic parametrised pipeline-stage register with valid/ready handshake, flush and bubble insertion.

---
 rtl/pipe_stage_buf_pkg.sv | 15 +
 rtl/pipe_slot.sv | 44 ++++
 rtl/pipe_stage_buf.sv | 183 ++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared state encodings and reset polarity for the
// pipeline-stage buffer and its storage slots.
package pipe_stage_buf_pkg;

  // Stage occupancy: no entry, one entry in main, main plus skid entry.
  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'd0,
    PIPE_ST_FULL  = 2'd1,
    PIPE_ST_SKID  = 2'd2
  } pipe_state_e;

  // Level of rst that holds the block in reset (rst is active low).
  localparam logic RST_ASSERTED = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: DATA_W payload register with async reset to RST_VAL.
// Ports:
//   clk, rst  - clock (rising edge), async reset (active low)
//   load      - capture d at the next edge
//   clear     - return to RST_VAL at the next edge (wins over load)
//   d, q      - payload in / held payload out
module pipe_slot
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned          DATA_W  = 32,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  // Next payload: clear beats load, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = RST_VAL;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-stage register with valid/ready handshake,
// flush, bubble insertion and a saturating stall counter.
// Optional feature macro: PIPE_SKID_EN adds a skid slot so in_ready is
// registered (no combinational out_ready -> in_ready path).
// Ports:
//   clk, rst            - clock (rising edge), async reset (active low)
//   flush               - drop all held entries and any in-transfer this cycle
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload (RST_VAL when idle)
//   stall_cnt           - saturating count of cycles with out_valid & ~out_ready
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned          DATA_W  = 32,
  parameter logic [DATA_W-1:0]    RST_VAL = '0,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              main_load, main_clr;
  logic [DATA_W-1:0] main_din;
  logic [DATA_W-1:0] main_q;

`ifdef PIPE_SKID_EN
  logic              in_ready_q, in_ready_d;
  logic              main_from_skid;
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] skid_q;
`endif

  // Next-state and slot control; flush overrides every transfer.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
`ifdef PIPE_SKID_EN
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
`endif
    if (flush) begin
      state_d  = PIPE_ST_EMPTY;
      main_clr = 1'b1;
`ifdef PIPE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        PIPE_ST_EMPTY: begin
          if (in_valid) begin
            state_d   = PIPE_ST_FULL;
            main_load = 1'b1;
          end
        end
        PIPE_ST_FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_load = 1'b1;
            end else begin
              state_d  = PIPE_ST_EMPTY;
              main_clr = 1'b1;
            end
          end
`ifdef PIPE_SKID_EN
          // Downstream stalled but upstream still pushing: park it in skid.
          else if (in_valid) begin
            state_d   = PIPE_ST_SKID;
            skid_load = 1'b1;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        PIPE_ST_SKID: begin
          // Skid entry moves up behind the departing main entry.
          if (out_ready) begin
            state_d        = PIPE_ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
`endif
        default: begin
          state_d  = PIPE_ST_EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
  end

  // Registered valid follows next-state occupancy.
  always_comb begin
    out_valid_d = (state_d != PIPE_ST_EMPTY);
  end

  // Stall counter saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

`ifdef PIPE_SKID_EN
  always_comb begin
    in_ready_d = (state_d != PIPE_ST_SKID);
    main_din   = main_from_skid ? skid_q : in_data;
  end
`else
  always_comb begin
    main_din = in_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      state_q     <= PIPE_ST_EMPTY;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;

  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .q     (skid_q)
  );
`else
  // Accept when empty or when the held entry leaves this cycle.
  assign in_ready = ~out_valid_q | out_ready;
`endif

  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_din),
    .q     (main_q)
  );

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed plus randomized checks of pipe_stage_buf
// against a FIFO-occupancy reference model (capacity 1, or 2 with
// PIPE_SKID_EN).
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] RST_VAL = 32'hBFC0_0000;
  localparam int unsigned SAT     = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] src[$];   // upstream entries still to be handed over
  logic [31:0] mq[$];    // model: entries held by the stage, oldest first
  int unsigned mcnt = 0; // model: stall counter
  logic        rdy_s;

  pipe_stage_buf #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model readiness: a capacity-limited FIFO; without skid the slot frees
  // in the same cycle the downstream takes it.
  function automatic logic model_ready();
    if (CAP == 2) return (mq.size() < 2);
    return (mq.size() == 0) || out_ready;
  endfunction

  // Reference model update at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit rdy;
      rdy = model_ready();
      if (mq.size() > 0 && !out_ready && mcnt != SAT) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back(in_data);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("cmp_out_data", out_data, (mq.size() > 0) ? mq[0] : RST_VAL);
      check("cmp_in_ready", 32'(in_ready), 32'(model_ready()));
      check("cmp_stall_cnt", 32'(stall_cnt), 32'(mcnt));
    end
  end

  // One clock of upstream/downstream activity; returns at posedge+1.
  task automatic cycle(input logic o_rdy, input logic fl);
    in_valid  = (src.size() > 0);
    in_data   = (src.size() > 0) ? src[0] : $urandom;
    out_ready = o_rdy;
    flush     = fl;
    @(negedge clk);
    rdy_s = in_ready;
    @(posedge clk);
    #1;
    if (in_valid && rdy_s) void'(src.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset for 3 cycles, then release.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'hBFC0_0000);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);

    // 2: stream with downstream always ready, one-cycle latency.
    src = '{32'h11, 32'h22, 32'h33};
    cycle(1'b1, 1'b0); check("stream_0", out_data, 32'h11);
    cycle(1'b1, 1'b0); check("stream_1", out_data, 32'h22);
    cycle(1'b1, 1'b0); check("stream_2", out_data, 32'h33);
    cycle(1'b1, 1'b0); check("stream_drain", 32'(out_valid), 32'h0);

    // 3: stall with upstream pushing; nothing lost, order kept.
    src = '{32'hA1};
    cycle(1'b1, 1'b0); check("stall_first", out_data, 32'hA1);
    src.push_back(32'hA2);
    src.push_back(32'hA3);
    repeat (4) cycle(1'b0, 1'b0);
    check("stall_hold", out_data, 32'hA1);
    check("stall_cnt4", 32'(stall_cnt), 32'd4);
    check("stall_in_ready", 32'(in_ready), 32'h0);
    check("stall_src_left", 32'(src.size()), (CAP == 2) ? 32'd1 : 32'd2);
    cycle(1'b1, 1'b0); check("release_0", out_data, 32'hA2);
    cycle(1'b1, 1'b0); check("release_1", out_data, 32'hA3);
    cycle(1'b1, 1'b0); check("release_done", 32'(out_valid), 32'h0);

    // 4: fill (and skid) then flush with a pending input.
    src = '{32'hB1, 32'hB2, 32'hB3};
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_data", out_data, 32'hBFC0_0000);
    check("flush_cnt", 32'(stall_cnt), 32'd5);
    src.delete();
    cycle(1'b1, 1'b0);
    check("flush_no_ghost", 32'(out_valid), 32'h0);

    // 5: long stall saturates the counter.
    src = '{32'hD1};
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);
    check("sat_cnt", 32'(stall_cnt), 32'd15);
    check("sat_hold", out_data, 32'hD1);
    cycle(1'b1, 1'b0);

    // 6: asynchronous reset between edges.
    src = '{32'hE1, 32'hE2, 32'hE3};
    cycle(1'b1, 1'b0);
    check("pre_arst", out_data, 32'hE1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data", out_data, 32'hBFC0_0000);
    check("arst_cnt", 32'(stall_cnt), 32'h0);
    src.delete();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (src.size() == 0 && $urandom_range(0, 3) != 0) src.push_back($urandom);
      cycle(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
